// File: rtl/mm_line_fetch.sv
// mm_line_fetch: fills one 64-bit cache line from a 32-bit backing store.
// A request from the cache is served with two word reads (offset 0, then offset 4).
// The assembled line is returned with a one-cycle rvalid_mm pulse.
// A per-word wait counter aborts a read that stalls too long and pulses err.
module mm_line_fetch #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        arvalid,
   input  logic [31:0] addr_mm,
   output logic        rvalid_mm,
   output logic [63:0] data_mm,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD0  = 3'd1,
      RD1  = 3'd2,
      RESP = 3'd3,
      HOLD = 3'd4
   } state_t;

   // Wide enough to hold TIMEOUT itself after an abort.
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_t           state;
   logic [31:0]      line_addr;
   logic [CNT_W-1:0] wait_cnt;
   logic             withdrawn;
   logic             timeout_hit;

   // The counter reaches TIMEOUT on the edge that ends the last permitted stall cycle.
   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

   // Request sequencing with all outputs registered; mem_ack wins over a coincident timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rvalid_mm <= 1'b0;
         data_mm   <= '0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         err       <= 1'b0;
         line_addr <= '0;
         wait_cnt  <= '0;
         withdrawn <= 1'b0;
      end else begin
         rvalid_mm <= 1'b0;
         err       <= 1'b0;
         case (state)
            IDLE: begin
               if (arvalid) begin
                  line_addr <= addr_mm & 32'hFFFF_FFF8;
                  mem_addr  <= addr_mm & 32'hFFFF_FFF8;
                  mem_req   <= 1'b1;
                  wait_cnt  <= '0;
                  withdrawn <= 1'b0;
                  state     <= RD0;
               end
            end
            RD0: begin
               if (!arvalid) begin
                  withdrawn <= 1'b1;
               end
               if (mem_ack) begin
                  data_mm[63:32] <= mem_rdata;
                  mem_addr       <= line_addr + 32'd4;
                  wait_cnt       <= '0;
                  state          <= RD1;
               end else if (timeout_hit) begin
                  wait_cnt <= wait_cnt + 1'b1;
                  err      <= 1'b1;
                  mem_req  <= 1'b0;
                  state    <= HOLD;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RD1: begin
               if (mem_ack) begin
                  data_mm[31:0] <= mem_rdata;
                  mem_req       <= 1'b0;
                  // A request withdrawn at any point of the fill gets no response.
                  if (withdrawn || !arvalid) begin
                     state <= IDLE;
                  end else begin
                     state <= RESP;
                  end
               end else if (timeout_hit) begin
                  wait_cnt <= wait_cnt + 1'b1;
                  err      <= 1'b1;
                  mem_req  <= 1'b0;
                  state    <= HOLD;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                  if (!arvalid) begin
                     withdrawn <= 1'b1;
                  end
               end
            end
            RESP: begin
               rvalid_mm <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               // The cache keeps arvalid high until its lookup hits; wait it out.
               if (!arvalid) begin
                  state <= IDLE;
               end
            end
            default: begin
               mem_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mm_line_fetch.md
MM_LINE_FETCH -- requirements
Module: mm_line_fetch

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for mem_ack on one word before aborting.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port arvalid, input, 1 bit: line-fill request from the cache, held high until the cache hits.
REQ-005 The block SHALL have port addr_mm, input, 32 bits: byte address of the missing word.
REQ-006 The block SHALL have port rvalid_mm, output, 1 bit: one-cycle pulse; data_mm is valid.
REQ-007 The block SHALL have port data_mm, output, 64 bits: the fetched line.
REQ-008 The block SHALL have port mem_req, output, 1 bit: word read request to the backing store.
REQ-009 The block SHALL have port mem_addr, output, 32 bits: word address for mem_req.
REQ-010 The block SHALL have port mem_rdata, input, 32 bits: read data, valid when mem_ack=1.
REQ-011 The block SHALL have port mem_ack, input, 1 bit: one-cycle read completion strobe.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse on a timeout abort.

Function
REQ-013 The block SHALL implement the FSM states IDLE, RD0, RD1, RESP, HOLD.
REQ-014 In IDLE with arvalid=1, the block SHALL latch line_addr = {addr_mm[31:3],3'b000} and go to RD0 on the next edge.
REQ-015 In RD0 the block SHALL drive mem_req=1 and mem_addr=line_addr; on mem_ack=1 it SHALL capture mem_rdata into data_mm[63:32] and go to RD1.
REQ-016 In RD1 the block SHALL drive mem_req=1 and mem_addr=line_addr+4; on mem_ack=1 it SHALL capture mem_rdata into data_mm[31:0] and go to RESP.
REQ-017 Word ordering SHALL be: byte offset 0 in data_mm[63:32], byte offset 4 in data_mm[31:0], matching the cache's select-bit (addr bit 2) word extraction.
REQ-018 mem_req SHALL be low in IDLE, RESP and HOLD, and SHALL drop in the cycle after mem_ack is sampled.
REQ-019 In RESP the block SHALL drive rvalid_mm=1 for exactly one cycle and then go to HOLD.
REQ-020 HOLD SHALL wait for arvalid=0 and then return to IDLE, so no second fetch starts while the cache still holds arvalid high after the fill.
REQ-021 data_mm SHALL stay stable from RESP until the next capture in RD0.
REQ-022 Minimum latency SHALL be: arvalid sampled in cycle 0 gives rvalid_mm in cycle 4 when mem_ack returns in the first cycle of each of RD0 and RD1.
REQ-023 A wait counter SHALL clear on entry to RD0 and to RD1 and increment each cycle without mem_ack.
REQ-024 If the wait counter reaches TIMEOUT, the block SHALL pulse err for one cycle, drop mem_req, skip rvalid_mm and go to HOLD.
REQ-025 If arvalid drops during RD0 or RD1, the block SHALL finish the outstanding word reads, suppress rvalid_mm, and go from RD1 completion directly to IDLE.
REQ-026 Changes on addr_mm after the latch SHALL be ignored until the block next enters IDLE.
REQ-027 A mem_ack in IDLE, RESP or HOLD SHALL be ignored.
REQ-028 If mem_ack and timeout occur in the same cycle, mem_ack SHALL take priority and no err pulse SHALL occur.

Reset
REQ-029 When rst_n=0, the block SHALL asynchronously go to IDLE and set rvalid_mm=0, data_mm=0, mem_req=0, mem_addr=0, err=0, line_addr=0 and the wait counter to 0.
REQ-030 Reset asserted mid-fetch SHALL abort immediately with no rvalid_mm pulse and no err pulse.
REQ-031 After rst_n deasserts, the first fetch SHALL begin only on an arvalid sampled high on a rising edge.

Verification
REQ-032 Basic fill: addr_mm=0x0000_1234, arvalid=1, mem_ack=1 in the first cycle of each word with rdata 0xAAAA_0001 then 0xBBBB_0002 -> mem_addr=0x1230 then 0x1234; data_mm=0xAAAA_0001_BBBB_0002; rvalid_mm pulses in cycle 4.
REQ-033 Hold: after the fill, arvalid stays high 3 more cycles -> no further mem_req and no second rvalid_mm; IDLE after arvalid=0.
REQ-034 Slow memory: mem_ack delayed 10 cycles per word -> mem_req held steady for 10 cycles each; rvalid_mm in cycle 22; err stays 0.
REQ-035 Timeout: TIMEOUT=8 with mem_ack never asserted -> err pulses once after 8 cycles in RD0; no rvalid_mm; HOLD until arvalid=0.
REQ-036 Withdrawn request: arvalid drops during RD0 -> both words still read; rvalid_mm stays 0; block returns to IDLE.
REQ-037 Reset mid-fetch: rst_n=0 during RD1 -> all outputs are 0 without waiting for a clock edge; a new request after reset completes normally.
